control_loop_pi_mc: RTL and testbench

Parametrised, time-multiplexed multi-channel PI controller with per-channel output limits and integrator anti-windup, in signed fixed point. One `sta` pulse runs all CH channels through a single shared datapath, one channel after another, and ends with a one-cycle `done_sig`. The block replaces pairs of fixed two-channel float PI-limit loops in the control layer. The caller computes no error: the block takes reference/feedback pairs directly.

---
 rtl/control_loop_pi_mc_if.sv | 31 +++
 rtl/control_loop_pi_mc.sv | 190 +++++++++++++++++++
 tb/tb_control_loop_pi_mc.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_loop_pi_mc_if.sv
// Bus bundle for the multi-channel PI controller: per-channel operand lanes,
// start/preset controls and the registered results with busy/done status.
interface control_loop_pi_mc_if #(
    parameter int CH = 2,
    parameter int W  = 32
);
    logic              control_valuation_sig;
    logic              sta;
    logic [CH*W-1:0]   ref_bus;
    logic [CH*W-1:0]   fb_bus;
    logic [CH*W-1:0]   kp_bus;
    logic [CH*W-1:0]   ki_bus;
    logic [CH*W-1:0]   upper_bus;
    logic [CH*W-1:0]   lower_bus;
    logic [CH*W-1:0]   preset_bus;
    logic [CH*W-1:0]   y_bus;
    logic              busy;
    logic              done_sig;

    modport master (
        output control_valuation_sig, sta, ref_bus, fb_bus, kp_bus, ki_bus,
               upper_bus, lower_bus, preset_bus,
        input  y_bus, busy, done_sig
    );

    modport slave (
        input  control_valuation_sig, sta, ref_bus, fb_bus, kp_bus, ki_bus,
               upper_bus, lower_bus, preset_bus,
        output y_bus, busy, done_sig
    );
endinterface

// File: rtl/control_loop_pi_mc.sv
// Time-multiplexed PI controller: one shared datapath walks every channel
// through ERR/MUL/SUM/OUT, with clamped (anti-windup) integrators per channel.
module control_loop_pi_mc #(
    parameter int CH   = 2,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_user,
    control_loop_pi_mc_if.slave bus
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, OUT} state_t;

    state_t r_state, w_next;

    logic [CHW-1:0]       r_ch;
    logic                 r_presetRun;
    logic                 r_done;
    logic signed [W-1:0]  r_ref [CH];
    logic signed [W-1:0]  r_fb [CH];
    logic signed [W-1:0]  r_preset [CH];
    logic signed [W-1:0]  r_integ [CH];
    logic signed [W-1:0]  r_y [CH];
    logic signed [W-1:0]  r_e;
    logic signed [W-1:0]  r_p;
    logic signed [W-1:0]  r_iInc;
    logic signed [W-1:0]  r_iNew;

    logic signed [W-1:0]  w_kp [CH];
    logic signed [W-1:0]  w_ki [CH];
    logic signed [W-1:0]  w_up [CH];
    logic signed [W-1:0]  w_lo [CH];
    logic                 w_last;

    logic signed [W-1:0]    w_kpSel, w_kiSel, w_upSel, w_loSel;
    logic signed [W-1:0]    w_refSel, w_fbSel, w_preSel, w_integSel;
    logic signed [W:0]      w_eWide;
    logic signed [2*W-1:0]  w_eX, w_kpX, w_kiX;
    logic signed [2*W-1:0]  w_prodP, w_prodI, w_shP, w_shI;
    logic signed [W:0]      w_iSum, w_iSrc, w_ySum;
    logic signed [W-1:0]    w_iNewC, w_yC;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        assign w_kp[k] = bus.kp_bus[k*W +: W];
        assign w_ki[k] = bus.ki_bus[k*W +: W];
        assign w_up[k] = bus.upper_bus[k*W +: W];
        assign w_lo[k] = bus.lower_bus[k*W +: W];
        assign bus.y_bus[k*W +: W] = r_y[k];
    end

    function automatic logic signed [W-1:0] satW1(input logic signed [W:0] x);
        if (x[W] != x[W-1])
            satW1 = x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            satW1 = x[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat2W(input logic signed [2*W-1:0] x);
        if (x[2*W-1:W-1] != {(W+1){x[2*W-1]}})
            sat2W = x[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sat2W = x[W-1:0];
    endfunction

    // Upper bound applied first, so an inverted window (lo > hi) yields lo.
    function automatic logic signed [W-1:0] clampW(input logic signed [W:0] x,
                                                   input logic signed [W-1:0] hi,
                                                   input logic signed [W-1:0] lo);
        logic signed [W:0] t, hiX, loX;
        hiX = {hi[W-1], hi};
        loX = {lo[W-1], lo};
        t   = x;
        if (t > hiX) t = hiX;
        if (t < loX) t = loX;
        clampW = t[W-1:0];
    endfunction

    assign w_last = (r_ch == CHW'(CH - 1));

    always_comb begin
        w_kpSel    = w_kp[r_ch];
        w_kiSel    = w_ki[r_ch];
        w_upSel    = w_up[r_ch];
        w_loSel    = w_lo[r_ch];
        w_refSel   = r_ref[r_ch];
        w_fbSel    = r_fb[r_ch];
        w_preSel   = r_preset[r_ch];
        w_integSel = r_integ[r_ch];
    end

    assign w_eWide = {w_refSel[W-1], w_refSel} - {w_fbSel[W-1], w_fbSel};

    // Full-width products; the arithmetic shift floors toward minus infinity.
    assign w_eX    = {{W{r_e[W-1]}}, r_e};
    assign w_kpX   = {{W{w_kpSel[W-1]}}, w_kpSel};
    assign w_kiX   = {{W{w_kiSel[W-1]}}, w_kiSel};
    assign w_prodP = w_kpX * w_eX;
    assign w_prodI = w_kiX * w_eX;
    assign w_shP   = w_prodP >>> FRAC;
    assign w_shI   = w_prodI >>> FRAC;

    assign w_iSum  = {w_integSel[W-1], w_integSel} + {r_iInc[W-1], r_iInc};
    assign w_iSrc  = r_presetRun ? {w_preSel[W-1], w_preSel} : w_iSum;
    assign w_iNewC = clampW(w_iSrc, w_upSel, w_loSel);
    assign w_ySum  = {r_p[W-1], r_p} + {r_iNew[W-1], r_iNew};
    assign w_yC    = clampW(w_ySum, w_upSel, w_loSel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else if (rst_user)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.sta) w_next = ERR;
            ERR:     w_next = MUL;
            MUL:     w_next = SUM;
            SUM:     w_next = OUT;
            OUT:     w_next = w_last ? IDLE : ERR;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (r_state != IDLE);
        bus.done_sig = r_done;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch        <= '0;
            r_presetRun <= 1'b0;
            r_done      <= 1'b0;
            r_e         <= '0;
            r_p         <= '0;
            r_iInc      <= '0;
            r_iNew      <= '0;
            for (int k = 0; k < CH; k++) begin
                r_ref[k]    <= '0;
                r_fb[k]     <= '0;
                r_preset[k] <= '0;
                r_integ[k]  <= '0;
                r_y[k]      <= '0;
            end
        end else if (rst_user) begin
            r_done <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                r_integ[k] <= '0;
                r_y[k]     <= '0;
            end
        end else begin
            r_done <= (r_state == OUT) && w_last;
            case (r_state)
                IDLE: begin
                    if (bus.sta) begin
                        r_ch        <= '0;
                        r_presetRun <= bus.control_valuation_sig;
                        for (int k = 0; k < CH; k++) begin
                            r_ref[k]    <= bus.ref_bus[k*W +: W];
                            r_fb[k]     <= bus.fb_bus[k*W +: W];
                            r_preset[k] <= bus.preset_bus[k*W +: W];
                        end
                    end
                end
                ERR: r_e <= satW1(w_eWide);
                MUL: begin
                    r_p    <= sat2W(w_shP);
                    r_iInc <= sat2W(w_shI);
                end
                SUM: r_iNew <= w_iNewC;
                OUT: begin
                    r_integ[r_ch] <= r_iNew;
                    r_y[r_ch]     <= r_presetRun ? r_iNew : w_yC;
                    if (!w_last) r_ch <= r_ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_loop_pi_mc.sv
// Directed bench for control_loop_pi_mc with CH=2, W=32, FRAC=16; expected
// values are hand-computed fixed-point results.
module tb_control_loop_pi_mc;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] LIM  = 32'h000A_0000;
    localparam logic [31:0] NLIM = 32'hFFF6_0000;

    logic clk = 1'b0;
    logic rst;
    logic rst_user;
    int   errCount   = 0;
    int   checkCount = 0;

    control_loop_pi_mc_if #(.CH(2), .W(32)) ifc ();

    control_loop_pi_mc #(.CH(2), .W(32), .FRAC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rst_user (rst_user),
        .bus      (ifc)
    );

    always #5 clk = ~clk;

    task automatic setLane(input int k, input logic [31:0] refV, input logic [31:0] fbV,
                           input logic [31:0] kpV, input logic [31:0] kiV,
                           input logic [31:0] upV, input logic [31:0] loV,
                           input logic [31:0] preV);
        ifc.ref_bus[k*32 +: 32]    = refV;
        ifc.fb_bus[k*32 +: 32]     = fbV;
        ifc.kp_bus[k*32 +: 32]     = kpV;
        ifc.ki_bus[k*32 +: 32]     = kiV;
        ifc.upper_bus[k*32 +: 32]  = upV;
        ifc.lower_bus[k*32 +: 32]  = loV;
        ifc.preset_bus[k*32 +: 32] = preV;
    endtask

    task automatic userClear();
        @(negedge clk);
        rst_user = 1'b1;
        @(negedge clk);
        rst_user = 1'b0;
    endtask

    // One full run; reports done position/count, busy deviations and lane-0 timing.
    task automatic applyStimulus(input logic presetRun, output int doneAt, output int doneCnt,
                                 output int busyErr, output logic [31:0] y0c4,
                                 output logic [31:0] y0c5);
        doneAt  = -1;
        doneCnt = 0;
        busyErr = 0;
        y0c4    = '0;
        y0c5    = '0;
        @(negedge clk);
        ifc.sta = 1'b1;
        ifc.control_valuation_sig = presetRun;
        @(posedge clk);
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 1) begin
                ifc.sta = 1'b0;
                ifc.control_valuation_sig = 1'b0;
            end
            if (ifc.done_sig) begin
                doneCnt++;
                doneAt = j;
            end
            if (ifc.busy !== (j <= 8)) busyErr++;
            if (j == 4) y0c4 = ifc.y_bus[31:0];
            if (j == 5) y0c5 = ifc.y_bus[31:0];
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rst_user = 1'b0;
        ifc.sta = 1'b0;
        ifc.control_valuation_sig = 1'b0;
        for (int k = 0; k < 2; k++) setLane(k, 0, 0, 0, 0, LIM, NLIM, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCount++;
        if (ifc.y_bus !== 64'd0 || ifc.busy !== 1'b0 || ifc.done_sig !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_hold: y=%h busy=%b done=%b want all 0",
                     ifc.y_bus, ifc.busy, ifc.done_sig);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkCount++;
            if (ifc.y_bus !== 64'd0 || ifc.busy !== 1'b0 || ifc.done_sig !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL reset_idle[%0d]: y=%h busy=%b done=%b want all 0",
                         i, ifc.y_bus, ifc.busy, ifc.done_sig);
            end
        end
    endtask

    task automatic test_proportional();
        int da, dc, be;
        logic [31:0] a4, a5;
        setLane(0, ONE, 32'h0000_4000, 32'h0002_0000, 0, LIM, NLIM, 0);
        setLane(1, 32'hFFFF_8000, 0, ONE, 0, LIM, NLIM, 0);
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (a4 !== 32'h0) begin
            errCount++; $display("[TB] FAIL prop_y0_cycle4: got %h want 00000000", a4);
        end
        checkCount++;
        if (a5 !== 32'h0001_8000) begin
            errCount++; $display("[TB] FAIL prop_y0_cycle5: got %h want 00018000", a5);
        end
        checkCount++;
        if (ifc.y_bus[63:32] !== 32'hFFFF_8000) begin
            errCount++; $display("[TB] FAIL prop_y1: got %h want ffff8000", ifc.y_bus[63:32]);
        end
        checkCount++;
        if (da !== 9 || dc !== 1) begin
            errCount++; $display("[TB] FAIL prop_done: at %0d count %0d want at 9 count 1", da, dc);
        end
        checkCount++;
        if (be !== 0) begin
            errCount++; $display("[TB] FAIL prop_busy: %0d cycles wrong want 0", be);
        end
    endtask

    task automatic test_integration();
        int da, dc, be;
        logic [31:0] a4, a5;
        userClear();
        setLane(0, ONE, 0, 0, 32'h0000_8000, LIM, NLIM, 0);
        setLane(1, 0, 0, 0, 0, LIM, NLIM, 0);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b0, da, dc, be, a4, a5);
            checkCount++;
            if (ifc.y_bus[31:0] !== 32'h8000 * (r + 1)) begin
                errCount++;
                $display("[TB] FAIL integ_run%0d: got %h want %h", r, ifc.y_bus[31:0], 32'h8000 * (r + 1));
            end
        end
    endtask

    task automatic test_antiwindup();
        int da, dc, be;
        logic [31:0] a4, a5;
        logic [31:0] expY [5] = '{32'h8000, 32'h10000, 32'h10000, 32'h10000, 32'h10000};
        userClear();
        setLane(0, ONE, 0, 0, 32'h0000_8000, ONE, NLIM, 0);
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b0, da, dc, be, a4, a5);
            checkCount++;
            if (ifc.y_bus[31:0] !== expY[r]) begin
                errCount++;
                $display("[TB] FAIL windup_run%0d: got %h want %h", r, ifc.y_bus[31:0], expY[r]);
            end
        end
        setLane(0, 0, ONE, 0, 32'h0000_8000, ONE, NLIM, 0);
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus[31:0] !== 32'h0000_8000) begin
            errCount++; $display("[TB] FAIL windup_unwind: got %h want 00008000", ifc.y_bus[31:0]);
        end
    endtask

    task automatic test_preset();
        int da, dc, be;
        logic [31:0] a4, a5;
        userClear();
        setLane(0, ONE, 0, 0, 32'h0000_8000, LIM, NLIM, 32'h0003_0000);
        setLane(1, 0, 0, 0, 0, LIM, NLIM, 32'h0014_0000);
        applyStimulus(1'b1, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus !== {32'h000A_0000, 32'h0003_0000}) begin
            errCount++; $display("[TB] FAIL preset_load: got %h want 000a000000030000", ifc.y_bus);
        end
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus !== {32'h000A_0000, 32'h0003_8000}) begin
            errCount++; $display("[TB] FAIL preset_resume: got %h want 000a000000038000", ifc.y_bus);
        end
    endtask

    task automatic test_boundaries();
        int da, dc, be;
        logic [31:0] a4, a5;
        userClear();
        setLane(0, 32'h7FFF_FFFF, 32'h8000_0000, ONE, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        setLane(1, 0, 0, 0, 0, 32'hFFFF_0000, ONE, 0);
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus[31:0] !== 32'h7FFF_FFFF) begin
            errCount++; $display("[TB] FAIL bound_err_sat: got %h want 7fffffff", ifc.y_bus[31:0]);
        end
        checkCount++;
        if (ifc.y_bus[63:32] !== ONE) begin
            errCount++; $display("[TB] FAIL bound_inverted_limits: got %h want 00010000", ifc.y_bus[63:32]);
        end
        setLane(0, 0, 32'h1, 32'h0000_8000, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        setLane(1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus[31:0] !== 32'hFFFF_FFFF) begin
            errCount++; $display("[TB] FAIL bound_floor: got %h want ffffffff", ifc.y_bus[31:0]);
        end
        checkCount++;
        if (ifc.y_bus[63:32] !== 32'h7FFF_FFFF) begin
            errCount++; $display("[TB] FAIL bound_prod_sat: got %h want 7fffffff", ifc.y_bus[63:32]);
        end
    endtask

    task automatic test_sta_ignored();
        int dc = 0, da = -1, be = 0;
        userClear();
        setLane(0, ONE, 0, ONE, 0, LIM, NLIM, 0);
        setLane(1, 0, 0, 0, 0, LIM, NLIM, 0);
        @(negedge clk);
        ifc.sta = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            ifc.sta = (j == 3);
            if (ifc.done_sig) begin dc++; da = j; end
            if (ifc.busy !== (j <= 8)) be++;
            @(posedge clk);
        end
        ifc.sta = 1'b0;
        checkCount++;
        if (dc !== 1 || da !== 9) begin
            errCount++; $display("[TB] FAIL sta_ignored_done: at %0d count %0d want at 9 count 1", da, dc);
        end
        checkCount++;
        if (be !== 0 || ifc.y_bus[31:0] !== ONE) begin
            errCount++;
            $display("[TB] FAIL sta_ignored_run: busyErr=%0d y0=%h want 0 and 00010000", be, ifc.y_bus[31:0]);
        end
    endtask

    task automatic test_rst_user_abort();
        int da, dc, be;
        logic [31:0] a4, a5;
        int lateDone = 0;
        userClear();
        setLane(0, ONE, 0, 0, 32'h0000_8000, LIM, NLIM, 0);
        setLane(1, ONE, 0, 0, 32'h0000_8000, LIM, NLIM, 0);
        applyStimulus(1'b0, da, dc, be, a4, a5);
        @(negedge clk);
        ifc.sta = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            ifc.sta = 1'b0;
            rst_user = (j == 6);
            if (j >= 7 && ifc.done_sig) lateDone++;
            if (j == 5) begin
                checkCount++;
                if (ifc.y_bus[31:0] !== 32'h0001_0000) begin
                    errCount++; $display("[TB] FAIL abort_pre_y0: got %h want 00010000", ifc.y_bus[31:0]);
                end
            end
            if (j == 7) begin
                checkCount++;
                if (ifc.y_bus !== 64'd0 || ifc.busy !== 1'b0) begin
                    errCount++;
                    $display("[TB] FAIL abort_clear: y=%h busy=%b want 0 and 0", ifc.y_bus, ifc.busy);
                end
            end
            @(posedge clk);
        end
        checkCount++;
        if (lateDone !== 0) begin
            errCount++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", lateDone);
        end
        applyStimulus(1'b0, da, dc, be, a4, a5);
        checkCount++;
        if (ifc.y_bus[31:0] !== 32'h0000_8000) begin
            errCount++; $display("[TB] FAIL abort_integ_cleared: got %h want 00008000", ifc.y_bus[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int doneErr = 0, busyErr = 0;
        userClear();
        setLane(0, ONE, 0, 0, 32'h0000_8000, LIM, NLIM, 0);
        setLane(1, 0, 0, 0, 0, LIM, NLIM, 0);
        @(negedge clk);
        ifc.sta = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            ifc.sta = (j == 9);
            if (ifc.done_sig !== (j == 9 || j == 18)) doneErr++;
            if (ifc.busy !== ((j >= 1 && j <= 8) || (j >= 10 && j <= 17))) busyErr++;
            @(posedge clk);
        end
        ifc.sta = 1'b0;
        checkCount++;
        if (doneErr !== 0) begin
            errCount++; $display("[TB] FAIL b2b_done: %0d cycles wrong want 0", doneErr);
        end
        checkCount++;
        if (busyErr !== 0) begin
            errCount++; $display("[TB] FAIL b2b_busy: %0d cycles wrong want 0", busyErr);
        end
        checkCount++;
        if (ifc.y_bus[31:0] !== 32'h0001_0000) begin
            errCount++; $display("[TB] FAIL b2b_y0: got %h want 00010000", ifc.y_bus[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integration();
        test_antiwindup();
        test_preset();
        test_boundaries();
        test_sta_ignored();
        test_rst_user_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
